row_frame_parser: RTL



---
 rtl/row_parser_pkg.sv | 15 +
 rtl/row_frame_parser_if.sv | 23 ++
 rtl/row_pingpong_buf.sv | 54 +++++
 rtl/row_frame_parser.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/row_parser_pkg.sv
// Shared types and default parameters for the framed row parser.
// Pure declarations: no logic, no latency, no flow control.
package row_parser_pkg;

    localparam int         N_PIX_DEF       = 32;
    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 100000;
    localparam int         CNT_W_DEF       = 16;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} rx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_WAIT} rp_state_t;

endpackage

// File: rtl/row_frame_parser_if.sv
// Byte-stream input and row-burst output of the parser; master is the parser side.
// Plain wires: in_valid is a strobe without backpressure, ds_idle gates each row start.
interface row_frame_parser_if;
    import row_parser_pkg::*;

    pixel_t in_data;
    logic   in_valid;
    logic   ds_idle;
    logic   start;
    pixel_t rx_data;
    logic   rx_valid;

    modport master (
        input  in_data, in_valid, ds_idle,
        output start, rx_data, rx_valid
    );

    modport slave (
        output in_data, in_valid, ds_idle,
        input  start, rx_data, rx_valid
    );

endinterface

// File: rtl/row_pingpong_buf.sv
// Two row banks with full flags; write and flag updates take effect next clock.
// Read is combinational from the selected bank; no backpressure, caller owns bank selection.
module row_pingpong_buf
    import row_parser_pkg::*;
#(
    parameter int N_PIX = N_PIX_DEF,
    parameter int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  pixel_t           wr_dat,
    input  logic             set_full,
    input  logic             set_bank,
    input  logic             clr_full,
    input  logic             clr_bank,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output pixel_t           rd_dat,
    output logic [1:0]       full
);

    pixel_t     mem [2][N_PIX];
    logic [1:0] full_next;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_bank][rd_idx];

    always_comb begin
        full_next = full;
        if (clr_full) begin
            full_next[clr_bank] = 1'b0;
        end
        if (set_full) begin
            full_next[set_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

endmodule

// File: rtl/row_frame_parser.sv
// Framed UART byte stream -> checksum-verified rows replayed as start + N_PIX beats; ROW_PARSER_STATS_EN builds the status counters.
// Replay begins the cycle after a good checksum byte if ds_idle; input is never stalled, frames without a free bank are dropped.
module row_frame_parser
    import row_parser_pkg::*;
#(
    parameter int         N_PIX       = N_PIX_DEF,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int         CNT_W       = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    row_frame_parser_if.master bus,
    output logic [CNT_W-1:0]   frame_ok_cnt,
    output logic [CNT_W-1:0]   crc_err_cnt,
    output logic [CNT_W-1:0]   timeout_cnt,
    output logic [CNT_W-1:0]   overrun_cnt
);

    localparam int               IDX_W    = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int               TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    rx_state_t        rx_state, rx_next;
    rp_state_t        rp_state, rp_next;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             wr_bank, rd_bank;
    pixel_t           sum, rd_dat;
    logic [TO_W-1:0]  idle_cnt;
    logic [1:0]       full;
    logic             wr_en, set_full, clr_full;
    logic             ok_inc, crc_inc, to_inc, ovr_inc;
    logic             sync_hit, bank_free, timeout_hit;
    logic             start_go, last_beat;

    // A bank released by the replay side this cycle already counts as free.
    assign bank_free   = !full[wr_bank] || (clr_full && (rd_bank == wr_bank));
    assign sync_hit    = (rx_state == HUNT) && bus.in_valid && (bus.in_data == SYNC_BYTE);
    assign timeout_hit = (rx_state != HUNT) && !bus.in_valid
                         && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= HUNT;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            HUNT: begin
                if (sync_hit && bank_free) rx_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (timeout_hit)                                rx_next = HUNT;
                else if (bus.in_valid && (wr_idx == LAST_IDX)) rx_next = CHECK;
            end
            CHECK: begin
                if (timeout_hit || bus.in_valid) rx_next = HUNT;
            end
            default: rx_next = HUNT;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        set_full = 1'b0;
        ok_inc   = 1'b0;
        crc_inc  = 1'b0;
        to_inc   = timeout_hit;
        ovr_inc  = sync_hit && !bank_free;
        case (rx_state)
            PAYLOAD: wr_en = bus.in_valid;
            CHECK: begin
                set_full = bus.in_valid && (bus.in_data == sum);
                ok_inc   = set_full;
                crc_inc  = bus.in_valid && (bus.in_data != sum);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx   <= '0;
            sum      <= '0;
            wr_bank  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            if (sync_hit) begin
                wr_idx <= '0;
                sum    <= '0;
            end else if (wr_en) begin
                wr_idx <= wr_idx + 1'b1;
                sum    <= sum + bus.in_data;
            end
            if (set_full) wr_bank <= ~wr_bank;
            if (bus.in_valid || (rx_state == HUNT)) idle_cnt <= '0;
            else                                    idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign start_go  = (rp_state == R_IDLE) && full[rd_bank] && bus.ds_idle;
    assign last_beat = (rp_state == R_BURST) && (rd_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_state <= R_IDLE;
        end else begin
            rp_state <= rp_next;
        end
    end

    always_comb begin
        rp_next = rp_state;
        case (rp_state)
            R_IDLE:  if (start_go)  rp_next = R_BURST;
            R_BURST: if (last_beat) rp_next = R_WAIT;
            R_WAIT:                 rp_next = R_IDLE;
            default:                rp_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.start    = start_go;
        bus.rx_valid = (rp_state == R_BURST);
        bus.rx_data  = (rp_state == R_BURST) ? rd_dat : '0;
        clr_full     = last_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx  <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (start_go)                   rd_idx <= '0;
            else if (rp_state == R_BURST)   rd_idx <= rd_idx + 1'b1;
            if (last_beat) rd_bank <= ~rd_bank;
        end
    end

    row_pingpong_buf #(.N_PIX(N_PIX), .IDX_W(IDX_W)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_idx   (wr_idx),
        .wr_dat   (bus.in_data),
        .set_full (set_full),
        .set_bank (wr_bank),
        .clr_full (clr_full),
        .clr_bank (rd_bank),
        .rd_bank  (rd_bank),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat),
        .full     (full)
    );

`ifdef ROW_PARSER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] ok_q, crc_q, to_q, ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q  <= '0;
            crc_q <= '0;
            to_q  <= '0;
            ovr_q <= '0;
        end else begin
            if (ok_inc  && (ok_q  != CNT_MAX)) ok_q  <= ok_q  + 1'b1;
            if (crc_inc && (crc_q != CNT_MAX)) crc_q <= crc_q + 1'b1;
            if (to_inc  && (to_q  != CNT_MAX)) to_q  <= to_q  + 1'b1;
            if (ovr_inc && (ovr_q != CNT_MAX)) ovr_q <= ovr_q + 1'b1;
        end
    end

    assign frame_ok_cnt = ok_q;
    assign crc_err_cnt  = crc_q;
    assign timeout_cnt  = to_q;
    assign overrun_cnt  = ovr_q;
`else
    logic unused_stats;
    assign unused_stats = ^{ok_inc, crc_inc, to_inc, ovr_inc};

    assign frame_ok_cnt = '0;
    assign crc_err_cnt  = '0;
    assign timeout_cnt  = '0;
    assign overrun_cnt  = '0;
`endif

endmodule
